// File: rtl/norm16_stage_pkg.sv
// Shared definitions for the norm16_stage normalization pipeline.
//   D_WIDTH    : mantissa width.
//   CNT_WIDTH  : width of a shift count covering 0..D_WIDTH-1.
//   EXP_WIDTH  : default exponent width.
//   stage_b_t  : payload registered in stage B (difference, LZA outputs, exponent).
package norm16_stage_pkg;

  localparam int D_WIDTH   = 16;
  localparam int CNT_WIDTH = 4;
  localparam int EXP_WIDTH = 8;

  typedef struct packed {
    logic [D_WIDTH-1:0]   diff;
    logic [CNT_WIDTH-1:0] sft_cnt;
    logic                 v;
    logic                 correct;
    logic [EXP_WIDTH-1:0] exp;
  } stage_b_t;

endpackage

// File: rtl/norm16_stage_lza16.sv
// lza16: leading-zero anticipator for a - b with a >= b.
//   a, b    : in  16-bit operands.
//   sft_cnt : out predicted leading-zero count of a - b (may be one short).
//   v       : out 1 when a == b (difference is zero, sft_cnt meaningless).
//   correct : out 1 when the prediction is one short and the shift needs +1.
//
// The prediction is the first bit where a and b differ, walked down through
// the run of borrow-propagating positions (a=0, b=1) directly below it. For
// a >= b the true leading one sits either at that predicted position or one
// below, so a single correction bit suffices; it is taken from the
// difference bit at the predicted position.
module lza16
  import norm16_stage_pkg::*;
(
  input  logic [D_WIDTH-1:0]   a,
  input  logic [D_WIDTH-1:0]   b,
  output logic [CNT_WIDTH-1:0] sft_cnt,
  output logic                 v,
  output logic                 correct
);

  logic [D_WIDTH-1:0]   diff;
  logic                 found;
  logic                 in_run;
  logic [CNT_WIDTH-1:0] pos;

  always_comb begin
    diff   = a - b;
    found  = 1'b0;
    in_run = 1'b0;
    pos    = '0;
    for (int i = D_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (a[i] ^ b[i]) begin
          found  = 1'b1;
          in_run = 1'b1;
          pos    = CNT_WIDTH'(i);
        end
      end else if (in_run) begin
        if (!a[i] && b[i]) pos = CNT_WIDTH'(i);
        else               in_run = 1'b0;
      end
    end
    sft_cnt = CNT_WIDTH'(D_WIDTH - 1) - pos;
    v       = ~found;
    correct = found & ~diff[pos];
  end

endmodule

// File: rtl/norm16_stage.sv
// norm16_stage: three-register pipeline (A, B, C) that subtracts an aligned
// mantissa pair, left-normalizes the difference using an LZA prediction plus
// its one-bit correction, and adjusts the exponent.
//   clk, rst            : clock, synchronous active-high reset.
//   in_valid/in_ready   : input handshake for a, b, exp_in (a >= b).
//   out_valid/out_ready : output handshake for the stage-C results.
//   mant_out, exp_out   : normalized mantissa and adjusted exponent.
//   zero                : a == b.
//   uflow               : shift was clamped to the exponent.
//   corr_flag           : LZA correction used for this result.
//   corr_cnt            : saturating count of corrected results.
module norm16_stage
  import norm16_stage_pkg::*;
#(
  parameter int EXP_W = EXP_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic [EXP_W-1:0]   exp_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] mant_out,
  output logic [EXP_W-1:0]   exp_out,
  output logic               zero,
  output logic               uflow,
  output logic               corr_flag,
  output logic [15:0]        corr_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_shamt(input logic [CNT_WIDTH-1:0] sft,
                                                     input logic                 corr);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, sft} + {{CNT_WIDTH{1'b0}}, corr};
    if (sum[CNT_WIDTH]) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    if (&cnt) return cnt;
    return cnt + 16'd1;
  endfunction

  logic               vld_p0, vld_p1, vld_p2;
  logic               adv_p0, adv_p1, adv_p2;
  logic [D_WIDTH-1:0] a_p0, b_p0;
  logic [EXP_W-1:0]   exp_p0;
  stage_b_t           pay_n, pay_p1;

  logic [CNT_WIDTH-1:0] lza_sft;
  logic                 lza_v, lza_correct;

  logic [CNT_WIDTH-1:0] shamt, shift;
  logic [D_WIDTH-1:0]   mant_n;
  logic [EXP_W-1:0]     exp_n;
  logic                 zero_n, uflow_n, corr_n;

  assign adv_p2    = ~vld_p2 | out_ready;
  assign adv_p1    = ~vld_p1 | adv_p2;
  assign adv_p0    = ~vld_p0 | adv_p1;
  assign in_ready  = adv_p0;
  assign out_valid = vld_p2;

  // ---- Stage A: operand capture ----
  always_ff @(posedge clk) begin
    if (rst)         vld_p0 <= 1'b0;
    else if (adv_p0) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv_p0 && in_valid) begin
      a_p0   <= a;
      b_p0   <= b;
      exp_p0 <= exp_in;
    end
  end

  // ---- A -> B: subtract and anticipate leading zeros in parallel ----
  lza16 u_lza (
    .a       (a_p0),
    .b       (b_p0),
    .sft_cnt (lza_sft),
    .v       (lza_v),
    .correct (lza_correct)
  );

  always_comb begin
    pay_n         = '0;
    pay_n.diff    = a_p0 - b_p0;
    pay_n.sft_cnt = lza_sft;
    pay_n.v       = lza_v;
    pay_n.correct = lza_correct;
    pay_n.exp     = exp_p0;
  end

  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0) pay_p1 <= pay_n;
  end

  // ---- B -> C: shift amount, exponent clamp, normalizing shift ----
  always_comb begin
    shamt   = sat_shamt(pay_p1.sft_cnt, pay_p1.correct);
    shift   = shamt;
    exp_n   = pay_p1.exp - EXP_W'(shamt);
    uflow_n = 1'b0;
    zero_n  = 1'b0;
    corr_n  = pay_p1.correct & ~pay_p1.v;
    // exp < shamt <= 15 here, so its low bits are the whole exponent
    if (pay_p1.exp < EXP_W'(shamt)) begin
      shift   = pay_p1.exp[CNT_WIDTH-1:0];
      exp_n   = '0;
      uflow_n = 1'b1;
    end
    mant_n = pay_p1.diff << shift;
    if (pay_p1.v) begin
      mant_n  = '0;
      exp_n   = '0;
      uflow_n = 1'b0;
      zero_n  = 1'b1;
    end
  end

  // ---- Stage C: result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      zero      <= 1'b0;
      uflow     <= 1'b0;
      corr_flag <= 1'b0;
      corr_cnt  <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mant_out  <= mant_n;
        exp_out   <= exp_n;
        zero      <= zero_n;
        uflow     <= uflow_n;
        corr_flag <= corr_n;
        if (corr_n) corr_cnt <= sat_inc(corr_cnt);
      end
    end
  end

endmodule

// File: tb/tb_norm16_stage.sv
module tb_norm16_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] mant_out;
  logic [7:0]  exp_out;
  logic        zero, uflow, corr_flag;
  logic [15:0] corr_cnt;

  always #5 clk = ~clk;

  norm16_stage #(.EXP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .zero      (zero),
    .uflow     (uflow),
    .corr_flag (corr_flag),
    .corr_cnt  (corr_cnt)
  );

  typedef struct {
    logic [15:0] mant;
    logic [7:0]  e;
    logic        zero;
    logic        uflow;
    logic        corr;
    logic [15:0] cnt;
  } res_t;

  res_t        exp_q[$];
  logic [15:0] cnt_m = '0;
  int          errors = 0;
  int          checks = 0;
  int          delivered = 0;

  // Reference: normalize by the true leading-zero count of the difference.
  // The anticipated position is the first differing bit walked down through
  // the a=0/b=1 run below it; a correction occurs when the true leading one
  // is not at that anticipated position.
  function automatic res_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic [7:0] ev, input logic [15:0] cnt_before);
    res_t        r;
    logic [15:0] d;
    logic [15:0] x;
    int          msb, lz, p, pred;
    d = av - bv;
    r.cnt = cnt_before;
    if (av == bv) begin
      r.mant = '0; r.e = '0; r.zero = 1'b1; r.uflow = 1'b0; r.corr = 1'b0;
      return r;
    end
    msb = $clog2(int'(d) + 1) - 1;
    lz  = 15 - msb;
    x   = av ^ bv;
    p   = $clog2(int'(x) + 1) - 1;
    pred = p;
    while (pred > 0 && av[pred-1] == 1'b0 && bv[pred-1] == 1'b1) pred--;
    r.corr = (msb != pred);
    r.zero = 1'b0;
    if (int'(ev) < lz) begin
      r.mant = d << ev; r.e = '0; r.uflow = 1'b1;
    end else begin
      r.mant = d << lz; r.e = ev - 8'(lz); r.uflow = 1'b0;
    end
    if (r.corr && cnt_before != 16'hFFFF) r.cnt = cnt_before + 16'd1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Scoreboard update at the active edge.
  always @(posedge clk) begin
    res_t r;
    if (rst === 1'b1) begin
      exp_q.delete();
      cnt_m = '0;
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        r = model(a, b, exp_in, cnt_m);
        cnt_m = r.cnt;
        exp_q.push_back(r);
      end
    end
  end

  // Output comparison every cycle a result is presented (including stalls).
  always @(negedge clk) begin
    res_t r;
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_cmp: got unexpected result mant=%h, required no valid output", mant_out);
      end else begin
        r = exp_q[0];
        if (mant_out !== r.mant || exp_out !== r.e || zero !== r.zero ||
            uflow !== r.uflow || corr_flag !== r.corr || corr_cnt !== r.cnt) begin
          errors++;
          $display("FAIL out_cmp: got mant=%h exp=%0d z=%b u=%b c=%b cnt=%0d required mant=%h exp=%0d z=%b u=%b c=%b cnt=%0d",
                   mant_out, exp_out, zero, uflow, corr_flag, corr_cnt,
                   r.mant, r.e, r.zero, r.uflow, r.corr, r.cnt);
        end
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] ev);
    bit ok;
    int n;
    n = 0;
    a = av; b = bv; exp_in = ev; in_valid = 1'b1;
    #1;
    do begin
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic [7:0] ev, input logic [15:0] em, input logic [7:0] ee,
                          input logic ez, input logic eu, input logic ec);
    send(av, bv, ev);
    chk({nm, "_lat_a"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_lat_b"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_lat_c"}, 32'(out_valid), 32'd1);
    chk({nm, "_mant"}, 32'(mant_out), 32'(em));
    chk({nm, "_exp"}, 32'(exp_out), 32'(ee));
    chk({nm, "_zero"}, 32'(zero), 32'(ez));
    chk({nm, "_uflow"}, 32'(uflow), 32'(eu));
    chk({nm, "_corr"}, 32'(corr_flag), 32'(ec));
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    res_t        r;
    logic [15:0] hm, hc;
    logic [7:0]  he;
    logic        hf;
    int          d0;
    bit          acc;
    logic [15:0] ra, rb, t;
    int          mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mant", 32'(mant_out), 32'd0);
    chk("rst_exp", 32'(exp_out), 32'd0);
    chk("rst_flags", {29'd0, zero, uflow, corr_flag}, 32'd0);
    chk("rst_cnt", 32'(corr_cnt), 32'd0);
    rst = 1'b0;

    // Pin the reference model to hand-computed values.
    r = model(16'h1000, 16'h0001, 8'd20, 16'd0);
    chk("model_corr", {r.mant, r.e, 3'b0, r.corr, r.cnt[3:0]}, {16'hFFF0, 8'd16, 3'b0, 1'b1, 4'd1});
    r = model(16'hC000, 16'h0000, 8'd5, 16'd0);
    chk("model_noshift", {r.mant, r.e, 6'b0, r.uflow, r.corr}, {16'hC000, 8'd5, 8'd0});
    r = model(16'h1234, 16'h1234, 8'd9, 16'd0);
    chk("model_zero", {r.mant, r.e, 5'b0, r.zero, r.uflow, r.corr}, {16'h0, 8'd0, 5'b0, 3'b100});
    r = model(16'h0010, 16'h0000, 8'd3, 16'd0);
    chk("model_uflow", {r.mant, r.e, 7'b0, r.uflow}, {16'h0080, 8'd0, 8'd1});

    // Directed cases with latency checks.
    directed("corr", 16'h1000, 16'h0001, 8'd20, 16'hFFF0, 8'd16, 1'b0, 1'b0, 1'b1);
    chk("corr_cnt1", 32'(corr_cnt), 32'd1);
    directed("noshift", 16'hC000, 16'h0000, 8'd5, 16'hC000, 8'd5, 1'b0, 1'b0, 1'b0);
    directed("zero", 16'h1234, 16'h1234, 8'd9, 16'h0000, 8'd0, 1'b1, 1'b0, 1'b0);
    directed("uflow", 16'h0010, 16'h0000, 8'd3, 16'h0080, 8'd0, 1'b0, 1'b1, 1'b0);
    drain();

    // Back-pressure: three items fill A/B/C, then a four-cycle stall.
    d0 = delivered;
    out_ready = 1'b0;
    send(16'h1000, 16'h0001, 8'd20);
    send(16'h8000, 16'h0001, 8'd30);
    send(16'h0F00, 16'h0100, 8'd12);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    hm = mant_out; he = exp_out; hf = corr_flag; hc = corr_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_hold", {mant_out, exp_out, 7'b0, corr_flag}, {hm, he, 7'b0, hf});
    chk("bp_hold_cnt", 32'(corr_cnt), 32'(hc));
    chk("bp_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(16'h4000, 16'h3FFF, 8'd40);
    send(16'h00FF, 16'h0000, 8'd2);
    drain();
    chk("bp_delivered", 32'(delivered - d0), 32'd5);

    // Reset with three items in flight.
    out_ready = 1'b0;
    send(16'h1000, 16'h0001, 8'd20);
    send(16'h2000, 16'h0001, 8'd20);
    send(16'h0400, 16'h0001, 8'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt", 32'(corr_cnt), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    directed("post_rst", 16'hC000, 16'h0000, 8'd5, 16'hC000, 8'd5, 1'b0, 1'b0, 1'b0);
    chk("post_rst_cnt", 32'(corr_cnt), 32'd0);
    drain();

    // Randomized traffic with random back-pressure.
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          mode = $urandom_range(0, 3);
          ra = 16'($urandom);
          rb = 16'($urandom);
          case (mode)
            0: if (ra < rb) begin t = ra; ra = rb; rb = t; end
            1: begin if (ra < 16'd32) ra = ra + 16'd32; rb = ra - 16'($urandom_range(1, 31)); end
            2: begin ra = 16'h0001 << $urandom_range(0, 15); rb = 16'($urandom_range(0, int'(ra))); end
            default: rb = ra;
          endcase
          a = ra; b = rb;
          exp_in = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
